// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between two producers.
// Grants are issued in bounded bursts, are held while the FIFO is full, and blocked cycles are counted.
module fifo_wr_arbiter #(
    parameter int DW    = 8,
    parameter int BURST = 4,
    parameter int SW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic [DW-1:0] din0,
    output logic          ack0,
    input  logic          req1,
    input  logic [DW-1:0] din1,
    output logic          ack1,
    input  logic          ffull,
    output logic          wr,
    output logic [DW-1:0] din,
    output logic [1:0]    gnt,
    output logic [SW-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    localparam logic [3:0] BMAX = 4'(BURST - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_last;
    logic          w_last_nxt;
    logic [3:0]    r_bcnt;
    logic [3:0]    w_bcnt_nxt;
    logic [SW-1:0] r_stall_cnt;
    logic          w_stall;

    function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
        return (v == {SW{1'b1}}) ? v : v + 1'b1;
    endfunction

    assign w_stall   = (req0 | req1) & ffull;
    assign stall_cnt = r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_last      <= 1'b1;
            r_bcnt      <= 4'd0;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_last      <= w_last_nxt;
            r_bcnt      <= w_bcnt_nxt;
            if (w_stall) r_stall_cnt <= sat_inc(r_stall_cnt);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_bcnt_nxt  = r_bcnt;
        ack0        = 1'b0;
        ack1        = 1'b0;
        wr          = 1'b0;
        din         = '0;
        gnt         = 2'b00;
        case (r_state)
            IDLE: begin
                // On contention the grant goes to whoever was not served last.
                if (req0 && (!req1 || r_last)) begin
                    w_state_nxt = G0;
                    w_bcnt_nxt  = 4'd0;
                end else if (req1) begin
                    w_state_nxt = G1;
                    w_bcnt_nxt  = 4'd0;
                end
            end
            G0: begin
                gnt  = 2'b01;
                din  = din0;
                ack0 = req0 & ~ffull;
                wr   = ack0;
                if (!ffull) begin
                    if (req0) begin
                        if (req1 && r_bcnt == BMAX) begin
                            w_state_nxt = G1;
                            w_bcnt_nxt  = 4'd0;
                            w_last_nxt  = 1'b0;
                        end else if (r_bcnt != BMAX) begin
                            w_bcnt_nxt = r_bcnt + 4'd1;
                        end
                    end else begin
                        w_state_nxt = req1 ? G1 : IDLE;
                        w_bcnt_nxt  = 4'd0;
                        w_last_nxt  = 1'b0;
                    end
                end
            end
            G1: begin
                gnt  = 2'b10;
                din  = din1;
                ack1 = req1 & ~ffull;
                wr   = ack1;
                if (!ffull) begin
                    if (req1) begin
                        if (req0 && r_bcnt == BMAX) begin
                            w_state_nxt = G0;
                            w_bcnt_nxt  = 4'd0;
                            w_last_nxt  = 1'b1;
                        end else if (r_bcnt != BMAX) begin
                            w_bcnt_nxt = r_bcnt + 4'd1;
                        end
                    end else begin
                        w_state_nxt = req0 ? G0 : IDLE;
                        w_bcnt_nxt  = 4'd0;
                        w_last_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule
